// File: rtl/alu_mdu.sv
// alu_mdu: handshaked ALU + iterative MUL/DIV (in: in_valid A B ALUControl out_ready; out: in_ready out_valid Result ResultHi Zero Overflow)
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Overflow
);
  localparam int M = WIDTH - 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} st_t;
  st_t st, nst;
  logic [WIDTH-1:0] hi, lo, rb, res, fres, fhi;
  logic [SHW-1:0] cnt;
  logic sa, sx, dv, ovf, fire, mdu;
  logic [WIDTH:0] madd, rs, dsub;
  logic [2*WIDTH-1:0] prod;
  assign in_ready = (st == IDLE) & (~out_valid | out_ready);
  assign fire = in_valid & in_ready;
  assign mdu = &ALUControl[3:2];
  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, rb} : '0);
  assign rs = {hi, lo[M]};
  assign dsub = rs - {1'b0, rb};
  assign prod = sx ? -{hi, lo} : {hi, lo};
  assign fres = dv ? ((sx & |rb) ? -lo : lo) : prod[M:0];
  assign fhi = dv ? (sa ? -hi : hi) : prod[2*WIDTH-1:WIDTH];
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (ALUControl)
      4'b0000: begin
        res = A + B;
        ovf = (A[M] == B[M]) & (res[M] != A[M]);
      end
      4'b0001: begin
        res = A - B;
        ovf = (A[M] != B[M]) & (res[M] != A[M]);
      end
      4'b0010: res = A & B;
      4'b0011: res = A | B;
      4'b0100: res = A ^ B;
      4'b0101: res = WIDTH'($signed(A) < $signed(B));
      4'b0110: res = WIDTH'(A < B);
      4'b0111: res = ~(A | B);
      4'b1000: res = A << B[SHW-1:0];
      4'b1001: res = A >> B[SHW-1:0];
      4'b1010: res = $signed(A) >>> B[SHW-1:0];
      default: res = '0;
    endcase
  end
  always_comb begin
    nst = st;
    nst = (st == IDLE) ? ((fire & mdu) ? (ALUControl[1] ? DIV : MUL) : IDLE) :
          (st == FIX) ? IDLE :
          (cnt == SHW'(WIDTH - 1)) ? FIX : st;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nst;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
      rb <= '0;
      cnt <= '0;
      sa <= 1'b0;
      sx <= 1'b0;
      dv <= 1'b0;
    end else if (fire) begin
      hi <= '0;
      lo <= (ALUControl[0] & A[M]) ? -A : A;
      rb <= (ALUControl[0] & B[M]) ? -B : B;
      cnt <= '0;
      sa <= ALUControl[0] & A[M];
      sx <= ALUControl[0] & (A[M] ^ B[M]);
      dv <= ALUControl[1];
    end else if (st == MUL) begin
      cnt <= cnt + 1'b1;
      hi <= madd[WIDTH:1];
      lo <= {madd[0], lo[M:1]};
    end else if (st == DIV) begin
      cnt <= cnt + 1'b1;
      hi <= dsub[WIDTH] ? rs[M:0] : dsub[M:0];
      lo <= {lo[M-1:0], ~dsub[WIDTH]};
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      Result <= '0;
      ResultHi <= '0;
      Zero <= 1'b0;
      Overflow <= 1'b0;
    end else if (fire & ~mdu) begin
      out_valid <= 1'b1;
      Result <= res;
      ResultHi <= '0;
      Zero <= res == '0;
      Overflow <= ovf;
    end else if (st == FIX) begin
      out_valid <= 1'b1;
      Result <= fres;
      ResultHi <= fhi;
      Zero <= fres == '0;
      Overflow <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu against a behavioural model
module tb_alu_mdu;
  localparam int W = 32;
  localparam int W2 = 2 * W;
  localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
  localparam longint MINS = -MAXS - 1;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic z;
    logic o;
    time t;
    int lat;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, Zero, Overflow;
  logic [W-1:0] A = '0, B = '0, Result, ResultHi;
  logic [3:0] ALUControl = '0;
  int total = 0, bad = 0;
  bit rnd = 0, held = 0;
  exp_t q[$];
  exp_t cur;
  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .ResultHi(ResultHi),
    .Zero(Zero), .Overflow(Overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic [W-1:0] h, output logic o);
    longint sa, sb, ua, ub, t;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sh = int'(ub % W);
    r = '0;
    h = '0;
    o = 1'b0;
    case (op)
      4'd0: begin t = sa + sb; r = W'(t); o = (t > MAXS) || (t < MINS); end
      4'd1: begin t = sa - sb; r = W'(t); o = (t > MAXS) || (t < MINS); end
      4'd2: r = W'(ua & ub);
      4'd3: r = W'(ua | ub);
      4'd4: r = W'(ua ^ ub);
      4'd5: r = W'(sa < sb);
      4'd6: r = W'(ua < ub);
      4'd7: r = W'(~(ua | ub));
      4'd8: r = W'(ua << sh);
      4'd9: r = W'(ua >> sh);
      4'd10: r = W'(sa >>> sh);
      4'd12: {h, r} = W2'(ua * ub);
      4'd13: {h, r} = W2'(sa * sb);
      4'd14: if (ub == 0) begin r = '1; h = a; end
             else begin r = W'(ua / ub); h = W'(ua % ub); end
      4'd15: if (sb == 0) begin r = '1; h = a; end
             else if (sa == MINS && sb == -1) begin r = MINV; h = '0; end
             else begin r = W'(sa / sb); h = W'(sa % sb); end
      default: r = '0;
    endcase
  endfunction
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return MINV;
      3: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) out_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input logic [W-1:0] h, input logic o);
    exp_t e;
    int n = 0;
    in_valid = 1;
    ALUControl = op;
    A = a;
    B = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      ALUControl = 4'($urandom);
      A = W'($urandom);
      B = W'($urandom);
      tick();
      @(negedge clk);
      n++;
    end
    chk("accept", 64'(in_ready), 64'(1));
    if (!in_ready) begin
      in_valid = 0;
      return;
    end
    ALUControl = op;
    A = a;
    B = b;
    @(posedge clk);
    e.r = r;
    e.h = h;
    e.z = r == '0;
    e.o = o;
    e.t = $time;
    e.lat = (op[3:2] == 2'b11) ? W + 2 : 1;
    q.push_back(e);
    #1;
    in_valid = 0;
    if (rnd) out_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r, h;
    logic o;
    model(op, a, b, r, h, o);
    send(op, a, b, r, h, o);
  endtask
  task automatic drain();
    int n = 0;
    rnd = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 500) begin
      tick();
      n++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst) held = 0;
    else if (out_valid) begin
      if (!held) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 64'(out_valid), 64'(0));
          cur.r = Result;
          cur.h = ResultHi;
          cur.z = Zero;
          cur.o = Overflow;
        end else begin
          cur = q.pop_front();
          chk("latency", 64'($time), 64'(cur.t + time'((cur.lat - 1) * 10 + 5)));
        end
      end
      chk("Result", 64'(Result), 64'(cur.r));
      chk("ResultHi", 64'(ResultHi), 64'(cur.h));
      chk("Zero", 64'(Zero), 64'(cur.z));
      chk("Overflow", 64'(Overflow), 64'(cur.o));
      if (!out_ready) chk("in_ready_stall", 64'(in_ready), 64'(0));
      held = !out_ready;
    end
  end
  initial begin
    int n;
    #1 rst = 0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_Result", 64'(Result), 64'(0));
    chk("rst_ResultHi", 64'(ResultHi), 64'(0));
    chk("rst_Zero", 64'(Zero), 64'(0));
    chk("rst_Overflow", 64'(Overflow), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1;
    out_ready = 1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    tick();
    send(4'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 32'h0, 1'b1);
    send(4'd1, 32'h5, 32'h5, 32'h0, 32'h0, 1'b0);
    send(4'd5, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0, 1'b0);
    send(4'd6, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
    send(4'd10, 32'h80000000, 32'h4, 32'hF8000000, 32'h0, 1'b0);
    send(4'd11, 32'h12345678, 32'h9, 32'h0, 32'h0, 1'b0);
    send(4'd1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 32'h0, 1'b1);
    send(4'd7, 32'h0F0F0000, 32'h000000F0, 32'hF0F0FF0F, 32'h0, 1'b0);
    drain();
    send(4'd13, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0);
    send(4'd12, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 32'h00000002, 1'b0);
    send(4'd15, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    send(4'd14, 32'h7, 32'h0, 32'hFFFFFFFF, 32'h7, 1'b0);
    send(4'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
    send(4'd15, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0);
    drain();
    out_ready = 0;
    send(4'd13, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("mul_done", 64'(out_valid), 64'(1));
    repeat (5) tick();
    out_ready = 1;
    send(4'd0, 32'h3, 32'h4, 32'h7, 32'h0, 1'b0);
    drain();
    in_valid = 1;
    ALUControl = 4'd15;
    A = 32'd100;
    B = 32'd3;
    @(negedge clk);
    chk("div_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1 in_valid = 0;
    repeat (9) tick();
    #2 rst = 0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_Result", 64'(Result), 64'(0));
    chk("abort_ResultHi", 64'(ResultHi), 64'(0));
    tick();
    rst = 1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    repeat (40) tick();
    rnd = 1;
    repeat (300) begin
      issue(4'($urandom), pick(), pick());
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
